booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Sequential, parametrised radix-2 Booth multiplier. Successor to the team's 4-bit combinational Booth block. Adds:
- configurable operand width;
- a start/done handshake;
- per-operation signed or unsigned mode;
- exact results for every operand pair, including the most-negative value.

It retires one Booth step per clock and serves as the shared multiply unit behind datapath blocks that can tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥ 2); product is 2·WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; accepted only when busy = 0
- signed_mode  input  1  1: operands are two's complement; 0: unsigned; sampled with start
- m  input  WIDTH  multiplicand, sampled with start
- q  input  WIDTH  multiplier, sampled with start
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse; product valid
- product  output  2·WIDTH  result; holds until the next accepted start

## Operation
- Reset (rst_n low at a clock edge):
  - state ← IDLE;
  - product, done, busy ← 0;
  - all internal registers ← 0.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- FSM states:
  - IDLE: waits for start. On start: load operands, cnt ← WIDTH+1, go to CALC, busy ← 1.
  - CALC: one Booth step per cycle, cnt decrements. When the step with cnt = 1 completes, go to DONE.
  - DONE: product ← low 2·WIDTH bits of {A,Q}; done ← 1; busy ← 0; go to IDLE.
- Operand extension:
  - m and q are extended to WIDTH+1 bits: sign-extended if signed_mode = 1, zero-extended otherwise.
  - A is a WIDTH+1-bit accumulator initialised to 0; q₋₁ is initialised to 0.
- Booth step, on the pair {Q[0], q₋₁}:
  - 01: A ← A + M
  - 10: A ← A − M
  - 00 or 11: A unchanged
  - Then {A,Q,q₋₁} is arithmetic-shifted right by 1; the sign bit of A is preserved.
  - All arithmetic is WIDTH+1 bits and wraps. This width is sufficient, so no overflow is observable.
- Results:
  - Exact for every input pair in both modes, e.g. −2^(WIDTH−1) · −2^(WIDTH−1) = 2^(2·WIDTH−2).
  - Exact for (2^WIDTH−1)² in unsigned mode.
- start while busy = 1 (CALC or DONE): ignored. No queuing, no effect on the operation in flight.
- Input stability: operands may change freely after acceptance; only the values sampled with start are used.
- signed_mode is latched at acceptance and holds for the whole operation.

## Timing
- Start accepted at edge k (state IDLE, start = 1):
  - busy = 1 after edge k;
  - CALC occupies edges k+1 … k+WIDTH+1;
  - DONE registers the result at edge k+WIDTH+2.
  - done = 1 and the new product are visible for exactly one cycle after edge k+WIDTH+2.
  - Latency: WIDTH+2 cycles from start to done (10 for WIDTH = 8). Fixed and independent of operand values.
- Back-to-back operation:
  - The earliest next start is accepted at the edge ending the done cycle (IDLE again).
  - Throughput: one result per WIDTH+3 cycles.
- busy falls in the same cycle that done rises.
- product is unchanged in every cycle except the DONE update.
- Reset has priority over all other events at the same edge, including start.

## Structure
- Shared package booth_pkg:
  - FSM state encoding constants: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  - Booth pair decode constants.
- Sub-module booth_step, purely combinational: inputs A, Q, q₋₁, M (WIDTH+1 bits); outputs the next A, Q, q₋₁.
- Top level holds the FSM, the counter (clog2(WIDTH+2) bits) and the operand/result registers.
- Expected size: about 150–250 lines of RTL.

## Test plan
All scenarios use WIDTH = 8.
- Signed basics: (3,7) → 21; (−3,7) → −21; (3,−7) → −21; (−3,−7) → 21; (−5,−6) → 30. Each done pulse lands exactly 10 cycles after start.
- Extremes, signed: (−128,−128) → 16384; (−128,127) → −16256; (0,−128) → 0. Unsigned: (255,255) → 65025; (128,2) → 256.
- Handshake:
  - start held high through an entire operation → exactly one done per accepted start;
  - operands changed during CALC → result uses the originally sampled values;
  - start during the done cycle → ignored.
- Reset mid-operation: rst_n low during the 4th CALC cycle → next cycle busy = 0, done = 0, product = 0. A new start afterwards completes normally.
- Back-to-back: start re-asserted the cycle after done → second result arrives WIDTH+3 = 11 cycles after the first done. product holds the first value until then.
- Randomised check: 1000 random operand pairs in both modes compared against a behavioural reference multiply.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and the Booth pair decode values.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q[0], q-1} pairs that modify the accumulator; the others leave it unchanged
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A,
// then an arithmetic right shift of {A, Q, q-1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] q,
    input  logic         qm1,
    input  logic [W-1:0] m,
    output logic [W-1:0] a_next,
    output logic [W-1:0] q_next,
    output logic         qm1_next
);

    logic [W-1:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], qm1})
            PAIR_ADD: sum = a + m;
            PAIR_SUB: sum = a - m;
            default:  sum = a;
        endcase
        a_next   = {sum[W-1], sum[W-1:1]};
        q_next   = {sum[0], q[W-1:1]};
        qm1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier, one step per clock. Operands are extended to
// WIDTH+1 bits so signed and unsigned operands share one signed datapath.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int XW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [XW-1:0]  a_reg, q_reg, m_reg;
    logic           qm1;
    logic [XW-1:0]  a_next, q_next;
    logic           qm1_next;

    booth_step #(.W(XW)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .qm1      (qm1),
        .m        (m_reg),
        .a_next   (a_next),
        .q_next   (q_next),
        .qm1_next (qm1_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            qm1     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= state_next;
            done  <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    // The mode only matters here: extension fixes it for the whole op
                    m_reg <= signed_mode ? {m[WIDTH-1], m} : {1'b0, m};
                    q_reg <= signed_mode ? {q[WIDTH-1], q} : {1'b0, q};
                    a_reg <= '0;
                    qm1   <= 1'b0;
                    cnt   <= CW'(WIDTH + 1);
                end
                CALC: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    qm1   <= qm1_next;
                    cnt   <= cnt - CW'(1);
                end
                DONE: product <= {a_reg[WIDTH-2:0], q_reg};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH = 8) against a plain
// arithmetic multiply reference.
module tb_booth_seq_mult;

    localparam int WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                signed_mode;
    logic [WIDTH-1:0]    m;
    logic [WIDTH-1:0]    q;
    logic                busy;
    logic                done;
    logic [2*WIDTH-1:0]  product;

    int n_checks = 0;
    int n_fail   = 0;

    booth_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .m           (m),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mult(input logic sm, input logic [7:0] a, input logic [7:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    // Issues one start (called at #1 after an edge, DUT idle); returns the
    // number of edges from acceptance to the done pulse, -1 on timeout.
    task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b, output int lat);
        signed_mode = sm; m = a; q = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; m = '0; q = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, product} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%0b done=%0b product=%0h, want all 0", busy, done, product);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_signed_basics();
        int ta[5]  = '{3, -3, 3, -3, -5};
        int tb_[5] = '{7, 7, -7, -7, -6};
        int te[5]  = '{21, -21, -21, 21, 30};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, 8'(ta[i]), 8'(tb_[i]), lat);
            n_checks++;
            if (lat !== 10) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want 10", i, lat);
            end
            n_checks++;
            if (product !== 16'(te[i])) begin
                n_fail++;
                $display("FAIL basic_product[%0d]: got %0d, want %0d", i, $signed(product), te[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic       ts[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int         ta[5]  = '{-128, -128, 0, 255, 128};
        int         tb_[5] = '{-128, 127, -128, 255, 2};
        logic [15:0] te[5] = '{16'd16384, 16'(-16256), 16'd0, 16'd65025, 16'd256};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ts[i], 8'(ta[i]), 8'(tb_[i]), lat);
            n_checks++;
            if (lat !== 10 || product !== te[i]) begin
                n_fail++;
                $display("FAIL extreme[%0d]: got %0h lat %0d, want %0h lat 10", i, product, lat, te[i]);
            end
        end
    endtask

    task automatic test_timing_flags();
        int cnt_busy = 0;
        int n_done = 0;
        signed_mode = 1'b0; m = 8'd12; q = 8'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_accept: busy=%0b done=%0b, want 1/0", busy, done);
        end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (busy) cnt_busy++;
            if (done) begin
                n_done++;
                n_checks++;
                if (busy !== 1'b0 || product !== 16'd132) begin
                    n_fail++;
                    $display("FAIL done_cycle: busy=%0b product=%0d, want 0/132", busy, product);
                end
            end
        end
        n_checks++;
        if (cnt_busy !== 9 || n_done !== 1) begin
            n_fail++;
            $display("FAIL pulse_widths: busy cycles %0d dones %0d, want 9 and 1", cnt_busy, n_done);
        end
    endtask

    task automatic test_start_held();
        int n_done = 0;
        signed_mode = 1'b1; m = 8'(-9); q = 8'd13; start = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (i == 10) start = 1'b0;
        end
        n_checks++;
        if (n_done !== 1 || product !== 16'(-117)) begin
            n_fail++;
            $display("FAIL start_held: dones %0d product %0d, want 1 and -117", n_done, $signed(product));
        end
    endtask

    task automatic test_operand_change();
        int lat = -1;
        signed_mode = 1'b1; m = 8'd25; q = 8'(-4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            m = 8'($urandom); q = 8'($urandom); signed_mode = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 10 || product !== 16'(-100)) begin
            n_fail++;
            $display("FAIL operand_change: got %0d lat %0d, want -100 lat 10", $signed(product), lat);
        end
    endtask

    task automatic test_start_in_done();
        int n_done = 0;
        signed_mode = 1'b0; m = 8'd200; q = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        // DUT now in DONE state; this start must be dropped
        m = 8'd1; q = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || product !== 16'd600) begin
            n_fail++;
            $display("FAIL start_in_done_first: done=%0b product=%0d, want 1/600", done, product);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        n_checks++;
        if (n_done !== 0 || product !== 16'd600) begin
            n_fail++;
            $display("FAIL start_in_done_ignored: activity %0d product %0d, want 0 and 600", n_done, product);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        signed_mode = 1'b1; m = 8'd50; q = 8'd50; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%0b done=%0b product=%0h, want 0/0/0", busy, done, product);
        end
        repeat (12) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_done: done=%0b, want 0", done);
            end
        end
        run_op(1'b1, 8'(-7), 8'(-8), lat);
        n_checks++;
        if (lat !== 10 || product !== 16'd56) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got %0d lat %0d, want 56 lat 10", product, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap = -1;
        run_op(1'b0, 8'd17, 8'd19, lat);
        n_checks++;
        if (lat !== 10 || product !== 16'd323) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d lat %0d, want 323 lat 10", product, lat);
        end
        signed_mode = 1'b1; m = 8'(-20); q = 8'd6; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin gap = i; break; end
            n_checks++;
            if (product !== 16'd323) begin
                n_fail++;
                $display("FAIL b2b_hold: product %0d at cycle %0d, want 323", product, i);
            end
        end
        n_checks++;
        if (gap !== 11 || product !== 16'(-120)) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d gap %0d, want -120 gap 11", $signed(product), gap);
        end
    endtask

    task automatic test_random();
        int lat;
        logic sm;
        logic [7:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            run_op(sm, a, b, lat);
            n_checks++;
            if (lat !== 10 || product !== ref_mult(sm, a, b)) begin
                n_fail++;
                $display("FAIL random[%0d]: sm=%0b %0h*%0h got %0h lat %0d, want %0h lat 10",
                         i, sm, a, b, product, lat, ref_mult(sm, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basics();
        test_extremes();
        test_timing_flags();
        test_start_held();
        test_operand_change();
        test_start_in_done();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
